// File: rtl/lcd_seq_if.sv
// Byte-in handshake plus LCD-slave bus between the sequencer (master) and its environment (slave).
// Carries status flags alongside so the whole block boundary is one bundle.
interface lcd_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       begintransfer;
    logic       init_done;
    logic       timeout_err;

    modport master (
        input  in_valid, in_rs, in_data, readdata,
        output in_ready, address, read, write, writedata, begintransfer, init_done, timeout_err
    );

    modport slave (
        output in_valid, in_rs, in_data, readdata,
        input  in_ready, address, read, write, writedata, begintransfer, init_done, timeout_err
    );
endinterface

// File: rtl/lcd_seq.sv
// HD44780-style LCD sequencer: power-on init, then busy-polled byte writes as SU/E/HOLD transfers.
// One byte in flight; in_ready drops on acceptance and returns once that byte's write HOLD is done.
module lcd_seq #(
    parameter int SU_CYCLES    = 2,
    parameter int E_CYCLES     = 12,
    parameter int HOLD_CYCLES  = 2,
    parameter int POR_CYCLES   = 750000,
    parameter int WAIT1_CYCLES = 205000,
    parameter int WAIT2_CYCLES = 5000,
    parameter int POLL_MAX     = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    lcd_seq_if.master   bus
);
    typedef enum logic [2:0] {POR_WAIT, INIT_WR, INIT_DLY, POLL, POLL_CHK, WRITE, IDLE} state_t;
    typedef enum logic [1:0] {PH_SU, PH_E, PH_HOLD} phase_t;

    localparam int DLY_MAX = (POR_CYCLES > WAIT1_CYCLES)
                           ? ((POR_CYCLES > WAIT2_CYCLES) ? POR_CYCLES : WAIT2_CYCLES)
                           : ((WAIT1_CYCLES > WAIT2_CYCLES) ? WAIT1_CYCLES : WAIT2_CYCLES);
    localparam int PH_MAX  = (SU_CYCLES > E_CYCLES)
                           ? ((SU_CYCLES > HOLD_CYCLES) ? SU_CYCLES : HOLD_CYCLES)
                           : ((E_CYCLES > HOLD_CYCLES) ? E_CYCLES : HOLD_CYCLES);
    localparam int DW = $clog2(DLY_MAX + 1);
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int QW = $clog2(POLL_MAX + 1);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] pollc_q, pollc_d;
    logic [2:0]    idx_q, idx_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          init_done_q, init_done_d;
    logic          tmo_q, tmo_d;

    logic [DW-1:0] dly_lim;
    logic [PW-1:0] ph_lim;
    logic          dly_last, ph_last, xfer, is_wr, xfer_done, in_ready;
    logic [7:0]    init_byte, cur_byte;
    logic          unused_rd;

    assign unused_rd = ^bus.readdata[6:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= POR_WAIT;
            phase_q     <= PH_SU;
            pcnt_q      <= '0;
            cnt_q       <= '0;
            pollc_q     <= '0;
            idx_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pcnt_q      <= pcnt_d;
            cnt_q       <= cnt_d;
            pollc_q     <= pollc_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            tmo_q       <= tmo_d;
        end
    end

    // Only the first inter-write delay is the long one; idx_q has already advanced past it.
    assign dly_lim  = (state_q == INIT_DLY) ? ((idx_q == 3'd1) ? DW'(WAIT1_CYCLES) : DW'(WAIT2_CYCLES))
                                            : DW'(POR_CYCLES);
    assign dly_last = (cnt_q >= dly_lim - 1'b1);

    always_comb begin
        case (phase_q)
            PH_SU:   ph_lim = PW'(SU_CYCLES);
            PH_E:    ph_lim = PW'(E_CYCLES);
            default: ph_lim = PW'(HOLD_CYCLES);
        endcase
    end
    assign ph_last = (pcnt_q >= ph_lim - 1'b1);

    always_comb begin
        case (idx_q)
            3'd4:    init_byte = 8'h0C;
            3'd5:    init_byte = 8'h01;
            3'd6:    init_byte = 8'h06;
            default: init_byte = 8'h38;
        endcase
    end

    assign is_wr    = (state_q == INIT_WR) || (state_q == WRITE);
    assign xfer     = is_wr || (state_q == POLL);
    assign cur_byte = init_done_q ? data_q : init_byte;
    assign in_ready = (state_q == IDLE) && init_done_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pcnt_d      = pcnt_q;
        cnt_d       = cnt_q;
        pollc_d     = pollc_q;
        idx_d       = idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        tmo_d       = tmo_q;
        xfer_done   = 1'b0;

        if (xfer) begin
            if (ph_last) begin
                pcnt_d = '0;
                case (phase_q)
                    PH_SU:   phase_d = PH_E;
                    PH_E:    phase_d = PH_HOLD;
                    default: begin
                        phase_d   = PH_SU;
                        xfer_done = 1'b1;
                    end
                endcase
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end

        if (state_q == POLL) begin
            if (phase_q == PH_E && ph_last)
                busy_d = bus.readdata[7];
            if (pollc_q < QW'(POLL_MAX))
                pollc_d = pollc_q + 1'b1;
        end

        case (state_q)
            POR_WAIT, INIT_DLY: begin
                if (dly_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == INIT_DLY && idx_q == 3'd3) ? POLL : INIT_WR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT_WR: if (xfer_done) begin
                idx_d   = idx_q + 3'd1;
                state_d = INIT_DLY;
            end
            POLL: if (xfer_done) state_d = POLL_CHK;
            POLL_CHK: begin
                if (!busy_q || pollc_q >= QW'(POLL_MAX)) begin
                    tmo_d   = tmo_q | busy_q;
                    pollc_d = '0;
                    state_d = WRITE;
                end else begin
                    state_d = POLL;
                end
            end
            WRITE: if (xfer_done) begin
                if (init_done_q) begin
                    state_d = IDLE;
                end else if (idx_q == 3'd6) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = POLL;
                end
            end
            IDLE: if (bus.in_valid && in_ready) begin
                rs_d    = bus.in_rs;
                data_d  = bus.in_data;
                state_d = POLL;
            end
            default: state_d = POR_WAIT;
        endcase
    end

    assign bus.in_ready      = in_ready;
    assign bus.address       = (state_q == POLL) ? 2'b01 : (is_wr ? {init_done_q & rs_q, 1'b0} : 2'b00);
    assign bus.writedata     = is_wr ? cur_byte : 8'h00;
    assign bus.read          = (state_q == POLL) && (phase_q == PH_E);
    assign bus.write         = is_wr && (phase_q == PH_E);
    assign bus.begintransfer = xfer && (phase_q == PH_E) && (pcnt_q == '0);
    assign bus.init_done     = init_done_q;
    assign bus.timeout_err   = tmo_q;
endmodule

// File: tb/tb_lcd_seq.sv
// Directed bench for lcd_seq: init sequence timing, data writes with busy polling, timeout, mid-write reset.
module tb_lcd_seq;
    localparam int SU = 1, EC = 3, HO = 1, POR = 20, W1 = 10, W2 = 5, PM = 50;
    localparam int XL = SU + EC + HO;

    typedef struct {
        logic       kind;
        logic [1:0] addr;
        logic [7:0] wd;
        int         len;
        int         start;
        int         stop;
    } xfer_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         busy;
        logic [1:0] exp_addr;
        int         exp_polls;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    int    cyc = 0;
    int    errs = 0;
    int    checks = 0;
    int    perr = 0;
    int    polls_total = 0;
    int    poll_base = 0;
    int    busy_n = 0;
    logic  rd_ff = 1'b0;
    xfer_t xq[$];
    xfer_t cur;
    logic       prev_s = 1'b0;
    logic       mon_s;
    logic [1:0] prev_a = '0;
    logic [7:0] prev_d = '0;

    lcd_seq_if bus();

    lcd_seq #(
        .SU_CYCLES(SU), .E_CYCLES(EC), .HOLD_CYCLES(HO), .POR_CYCLES(POR),
        .WAIT1_CYCLES(W1), .WAIT2_CYCLES(W2), .POLL_MAX(PM)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.readdata = rd_ff ? 8'hFF : (((polls_total - poll_base) < busy_n) ? 8'h80 : 8'h00);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pfail(input string name, input int act, input int exp);
        perr++;
        $display("FAIL proto_%s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    // Protocol monitor: records every strobe transfer and checks bus stability around it.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_s = 1'b0;
        end else begin
            mon_s = bus.read | bus.write;
            if (bus.read && bus.write) pfail("rw_both", 1, 0);
            if (mon_s && !prev_s) begin
                if (bus.address !== prev_a)   pfail("su_addr", int'(prev_a), int'(bus.address));
                if (bus.writedata !== prev_d) pfail("su_wdata", int'(prev_d), int'(bus.writedata));
                if (bus.begintransfer !== 1'b1) pfail("bt_rise", int'(bus.begintransfer), 1);
                cur.kind  = bus.write;
                cur.addr  = bus.address;
                cur.wd    = bus.writedata;
                cur.len   = 1;
                cur.start = cyc;
            end else if (mon_s) begin
                if (bus.address !== cur.addr) pfail("e_addr", int'(bus.address), int'(cur.addr));
                if (bus.writedata !== cur.wd) pfail("e_wdata", int'(bus.writedata), int'(cur.wd));
                if (bus.begintransfer !== 1'b0) pfail("bt_extra", int'(bus.begintransfer), 0);
                cur.len++;
            end else begin
                if (bus.begintransfer !== 1'b0) pfail("bt_idle", int'(bus.begintransfer), 0);
                if (prev_s) begin
                    if (bus.address !== cur.addr) pfail("hold_addr", int'(bus.address), int'(cur.addr));
                    if (bus.writedata !== cur.wd) pfail("hold_wdata", int'(bus.writedata), int'(cur.wd));
                    cur.stop = cyc - 1;
                    xq.push_back(cur);
                    if (!cur.kind) polls_total++;
                end
            end
            prev_s = mon_s;
            prev_a = bus.address;
            prev_d = bus.writedata;
        end
    end

    task automatic wait_ready(input int bound, output int rc);
        rc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                rc = cyc;
                break;
            end
        end
    endtask

    // Called at a negedge with in_ready high; returns the posedge count of the accepting edge.
    task automatic send_byte(input logic rs, input logic [7:0] d, output int acc);
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        @(negedge clk);
        acc = cyc;
        bus.in_valid = 1'b0;
        bus.in_rs    = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic split(output int nw, output int nr, output xfer_t w0, output xfer_t r0);
        nw = 0;
        nr = 0;
        w0 = '{1'b0, 2'b00, 8'h00, 0, 0, 0};
        r0 = w0;
        foreach (xq[i]) begin
            if (xq[i].kind) begin
                if (nw == 0) w0 = xq[i];
                nw++;
            end else begin
                if (nr == 0) r0 = xq[i];
                nr++;
            end
        end
    endtask

    initial begin
        vec_t       vt[4];
        logic [7:0] exp_init[7];
        xfer_t      w[$];
        xfer_t      w0, r0;
        int rc, acc, rel, nw, nr, done_cyc;

        vt[0] = '{1'b1, 8'h41, 0, 2'b10, 1};
        vt[1] = '{1'b0, 8'h80, 0, 2'b00, 1};
        vt[2] = '{1'b1, 8'h5A, 4, 2'b10, 5};
        vt[3] = '{1'b0, 8'hC3, 2, 2'b00, 3};
        exp_init = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

        bus.in_valid = 1'b0;
        bus.in_rs    = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_write", int'(bus.write), 0);
        chk("rst_read", int'(bus.read), 0);
        chk("rst_address", int'(bus.address), 0);
        chk("rst_writedata", int'(bus.writedata), 0);
        chk("rst_init_done", int'(bus.init_done), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        reset_n = 1'b1;
        rel = cyc;

        // Init sequence
        done_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.init_done) begin
                done_cyc = cyc;
                break;
            end
        end
        chk("init_done_seen", int'(done_cyc >= 0), 1);
        chk("init_in_ready", int'(bus.in_ready), 1);
        w.delete();
        nr = 0;
        foreach (xq[i]) begin
            if (xq[i].kind) w.push_back(xq[i]);
            else nr++;
        end
        chk("init_nwrites", w.size(), 7);
        chk("init_npolls", nr, 4);
        foreach (w[i]) begin
            if (i < 7) begin
                chk($sformatf("init_wd%0d", i), int'(w[i].wd), int'(exp_init[i]));
                chk($sformatf("init_addr%0d", i), int'(w[i].addr), 0);
                chk($sformatf("init_len%0d", i), w[i].len, EC);
            end
        end
        if (w.size() == 7) begin
            chk("init_por_gap", w[0].start - rel, POR + SU);
            chk("init_wait1_gap", w[1].start - w[0].stop, HO + W1 + SU + 1);
            chk("init_wait2a_gap", w[2].start - w[1].stop, HO + W2 + SU + 1);
            chk("init_wait2b_gap", xq[3].start - w[2].stop, HO + W2 + SU + 1);
            chk("init_done_rise", done_cyc - w[6].stop, HO + 1);
        end

        // Data writes from the vector table
        for (int v = 0; v < 4; v++) begin
            xq.delete();
            busy_n    = vt[v].busy;
            poll_base = polls_total;
            send_byte(vt[v].rs, vt[v].data, acc);
            chk($sformatf("v%0d_ready_low", v), int'(bus.in_ready), 0);
            wait_ready(600, rc);
            chk($sformatf("v%0d_ready_back", v), int'(rc >= 0), 1);
            split(nw, nr, w0, r0);
            chk($sformatf("v%0d_npolls", v), nr, vt[v].exp_polls);
            chk($sformatf("v%0d_nwrites", v), nw, 1);
            chk($sformatf("v%0d_poll_addr", v), int'(r0.addr), 1);
            chk($sformatf("v%0d_addr", v), int'(w0.addr), int'(vt[v].exp_addr));
            chk($sformatf("v%0d_wd", v), int'(w0.wd), int'(vt[v].data));
            chk($sformatf("v%0d_wlen", v), w0.len, EC);
            chk($sformatf("v%0d_ready_after_hold", v), rc - w0.stop, HO + 1);
            if (vt[v].busy == 0)
                chk($sformatf("v%0d_latency_bound", v), int'((w0.start - acc) <= 2 * XL), 1);
            chk($sformatf("v%0d_tmo", v), int'(bus.timeout_err), 0);
        end

        // Timeout: busy never clears
        xq.delete();
        rd_ff = 1'b1;
        send_byte(1'b1, 8'h7E, acc);
        wait_ready(1000, rc);
        chk("tmo_ready_back", int'(rc >= 0), 1);
        split(nw, nr, w0, r0);
        chk("tmo_npolls", nr, PM / XL);
        chk("tmo_nwrites", nw, 1);
        chk("tmo_wd", int'(w0.wd), 8'h7E);
        chk("tmo_flag", int'(bus.timeout_err), 1);
        rd_ff = 1'b0;
        busy_n = 0;
        poll_base = polls_total;
        xq.delete();
        send_byte(1'b0, 8'h33, acc);
        wait_ready(600, rc);
        split(nw, nr, w0, r0);
        chk("tmo_next_wd", int'(w0.wd), 8'h33);
        chk("tmo_next_npolls", nr, 1);
        chk("tmo_sticky", int'(bus.timeout_err), 1);

        // Reset in the E phase of a write
        xq.delete();
        send_byte(1'b1, 8'h55, acc);
        rc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.write) begin
                rc = cyc;
                break;
            end
        end
        chk("rstmid_write_seen", int'(rc >= 0), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_write_drop", int'(bus.write), 0);
        chk("rstmid_address", int'(bus.address), 0);
        chk("rstmid_writedata", int'(bus.writedata), 0);
        chk("rstmid_init_done", int'(bus.init_done), 0);
        chk("rstmid_tmo_clr", int'(bus.timeout_err), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        rc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.write) begin
                rc = cyc;
                break;
            end
        end
        chk("rstmid_por_restart", rc - rel, POR + SU);
        chk("rstmid_first_byte", int'(bus.writedata), 8'h38);
        chk("rstmid_init_low", int'(bus.init_done), 0);

        chk("protocol", perr, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
